// File: rtl/if_id_buf_pkg.sv
// Shared fetch/decode definitions: instruction constants, stall-vector
// encoding and the payload that travels from fetch to decode.
package if_id_buf_pkg;

    localparam int          REG_BUS     = 32;
    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
    localparam logic        STOP        = 1'b1;
    localparam logic        NO_STOP     = 1'b0;
    localparam int          STALL_IF_ID = 1;
    localparam int          STALL_ID_EX = 2;

    // One fetched instruction together with everything that must stay with it.
    typedef struct packed {
        logic [REG_BUS-1:0] pc;
        logic [REG_BUS-1:0] ins;
        logic [REG_BUS-1:0] next_pc;
        logic               next_taken;
        logic [REG_BUS-1:0] exception;
    } fetch_beat_t;

    localparam int BEAT_W = $bits(fetch_beat_t);

    // Payload presented to decode when no real instruction is available.
    function automatic fetch_beat_t nop_beat();
        fetch_beat_t b;
        b.pc         = ZERO_WORD;
        b.ins        = NOP_INST;
        b.next_pc    = ZERO_WORD;
        b.next_taken = 1'b0;
        b.exception  = ZERO_WORD;
        return b;
    endfunction

endpackage

// File: rtl/if_id_fifo.sv
// Generic synchronous FIFO with push, pop, flush and an occupancy count.
// The head entry is visible on rdata_o without a read latency.
module if_id_fifo #(
    parameter  int DEPTH = 2,
    parameter  int W     = 129,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     wdata_i,
    output logic [W-1:0]     rdata_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic [W-1:0]     mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i & (count_q != FULL_COUNT);
    assign do_pop  = pop_i  & (count_q != '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointer/count values; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is not reset; count gates every read so stale contents are never observed.
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/if_id_buf.sv
// Fetch-to-decode boundary: a small instruction queue plus the output
// register feeding decode, honouring the ctrl stall vector and flush.
module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_pc_i,
    input  logic [31:0] fetch_ins_i,
    input  logic [31:0] fetch_next_pc_i,
    input  logic        fetch_next_taken_i,
    input  logic [31:0] fetch_exception_i,
    output logic [31:0] pc_o,
    output logic [31:0] ins_o,
    output logic [31:0] next_pc_o,
    output logic        next_taken_o,
    output logic [31:0] exception_o,
    output logic        ins_valid_o
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    fetch_beat_t    in_beat;
    fetch_beat_t    head_beat;
    fetch_beat_t    out_q, out_d;
    logic           valid_q, valid_d;
    logic [PTR_W:0] count;
    logic           push;
    logic           advance;
    logic           bypass;
    logic           fifo_push;
    logic           fifo_pop;
    logic           unused_stall;

    // Only the if_id and id_ex bits of the stall vector matter here.
    assign unused_stall = ^{stall_i[5:3], stall_i[0]};

    assign in_beat = '{pc: fetch_pc_i, ins: fetch_ins_i, next_pc: fetch_next_pc_i,
                       next_taken: fetch_next_taken_i, exception: fetch_exception_i};

    assign fetch_ready_o = (count != FULL_COUNT);
    assign push          = fetch_valid_i & fetch_ready_o & ~flush_i;
    assign advance       = ~flush_i & (stall_i[STALL_IF_ID] == NO_STOP);
    // An empty queue lets the incoming beat skip straight into the output register.
    assign bypass        = advance & (count == '0) & push;
    assign fifo_push     = push & ~bypass;
    assign fifo_pop      = advance & (count != '0);

    if_id_fifo #(
        .DEPTH (DEPTH),
        .W     (BEAT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (in_beat),
        .rdata_o (head_beat),
        .count_o (count)
    );

    // Output register next-state: flush, then bubble/hold stalls, then advance.
    always_comb begin
        // NOTE: defaults first so every path assigns out_d/valid_d and no latch is inferred.
        out_d   = out_q;
        valid_d = valid_q;
        if (flush_i) begin
            out_d   = nop_beat();
            valid_d = 1'b0;
        end else if (stall_i[STALL_IF_ID] == STOP) begin
            if (stall_i[STALL_ID_EX] == NO_STOP) begin
                out_d   = nop_beat();
                valid_d = 1'b0;
            end
        end else if (count != '0) begin
            out_d   = head_beat;
            valid_d = 1'b1;
        end else if (push) begin
            out_d   = in_beat;
            valid_d = 1'b1;
        end else begin
            out_d   = nop_beat();
            valid_d = 1'b0;
        end
    end

    // Output register with synchronous reset to the NOP payload.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q   <= nop_beat();
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o         = out_q.pc;
    assign ins_o        = out_q.ins;
    assign next_pc_o    = out_q.next_pc;
    assign next_taken_o = out_q.next_taken;
    assign exception_o  = out_q.exception;
    assign ins_valid_o  = valid_q;

endmodule

// File: tb/tb_if_id_buf.sv
// Self-checking bench for if_id_buf: a queue-based reference model is
// stepped every clock and compared against the DUT on the falling edge,
// with directed scenarios pinning literal values and a randomized soak.
module tb_if_id_buf;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_i;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_pc_i;
    logic [31:0] fetch_ins_i;
    logic [31:0] fetch_next_pc_i;
    logic        fetch_next_taken_i;
    logic [31:0] fetch_exception_i;
    logic [31:0] pc_o;
    logic [31:0] ins_o;
    logic [31:0] next_pc_o;
    logic        next_taken_o;
    logic [31:0] exception_o;
    logic        ins_valid_o;

    if_id_buf #(.DEPTH(DEPTH)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .stall_i            (stall_i),
        .flush_i            (flush_i),
        .fetch_valid_i      (fetch_valid_i),
        .fetch_ready_o      (fetch_ready_o),
        .fetch_pc_i         (fetch_pc_i),
        .fetch_ins_i        (fetch_ins_i),
        .fetch_next_pc_i    (fetch_next_pc_i),
        .fetch_next_taken_i (fetch_next_taken_i),
        .fetch_exception_i  (fetch_exception_i),
        .pc_o               (pc_o),
        .ins_o              (ins_o),
        .next_pc_o          (next_pc_o),
        .next_taken_o       (next_taken_o),
        .exception_o        (exception_o),
        .ins_valid_o        (ins_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: queued beats {pc, ins, next_pc, taken, exc} plus the decode-side view.
    logic [128:0] mq [$];
    logic [128:0] m_out;
    logic         m_valid;
    bit           m_known = 0;
    localparam logic [128:0] NOP_VIEW = {32'h0, 32'h0000_0013, 32'h0, 1'b0, 32'h0};

    task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [128:0] in_view();
        return {fetch_pc_i, fetch_ins_i, fetch_next_pc_i, fetch_next_taken_i, fetch_exception_i};
    endfunction

    function automatic logic [128:0] out_view();
        return {pc_o, ins_o, next_pc_o, next_taken_o, exception_o};
    endfunction

    // Present a beat with the given pc and randomized side fields.
    task automatic offer(input logic [31:0] pc);
        fetch_valid_i      = 1'b1;
        fetch_pc_i         = pc;
        fetch_ins_i        = $urandom;
        fetch_next_pc_i    = pc + 32'd4;
        fetch_next_taken_i = 1'($urandom_range(0, 1));
        fetch_exception_i  = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
    endtask

    // Apply one clock edge to the model using the inputs held across it.
    task automatic model_step();
        bit can_take, take;
        if (rst_i) begin
            mq.delete();
            m_out   = NOP_VIEW;
            m_valid = 1'b0;
            m_known = 1;
            return;
        end
        can_take = (mq.size() < DEPTH);
        take     = fetch_valid_i && can_take && !flush_i;
        if (flush_i) begin
            mq.delete();
            m_out   = NOP_VIEW;
            m_valid = 1'b0;
        end else if (stall_i[1]) begin
            if (!stall_i[2]) begin
                m_out   = NOP_VIEW;
                m_valid = 1'b0;
            end
            if (take) mq.push_back(in_view());
        end else begin
            if (take) mq.push_back(in_view());
            if (mq.size() > 0) begin
                m_out   = mq.pop_front();
                m_valid = 1'b1;
            end else begin
                m_out   = NOP_VIEW;
                m_valid = 1'b0;
            end
        end
    endtask

    // One clock: check ready before the edge, step the model, compare after the edge.
    task automatic cycle();
        if (m_known)
            check("fetch_ready", 129'(fetch_ready_o), 129'(mq.size() != DEPTH));
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (m_known) begin
            check("out_payload", out_view(), m_out);
            check("ins_valid", 129'(ins_valid_o), 129'(m_valid));
        end
    endtask

    task automatic idle_inputs();
        rst_i         = 1'b0;
        flush_i       = 1'b0;
        stall_i       = 6'b0;
        fetch_valid_i = 1'b0;
    endtask

    initial begin
        idle_inputs();
        fetch_pc_i = '0; fetch_ins_i = '0; fetch_next_pc_i = '0;
        fetch_next_taken_i = 1'b0; fetch_exception_i = '0;
        @(negedge clk);

        // Reset with a beat offered: nothing may leak through.
        rst_i = 1'b1;
        offer(32'h0000_0aa0);
        cycle();
        cycle();
        idle_inputs();
        cycle();
        check("reset_ready", 129'(fetch_ready_o), 129'(1'b1));
        check("reset_valid", 129'(ins_valid_o), 129'(1'b0));
        check("reset_ins", 129'(ins_o), 129'(32'h0000_0013));
        check("reset_pc", 129'(pc_o), 129'(32'h0));

        // Streaming: one-cycle latency, one instruction per cycle.
        offer(32'h100); cycle(); check("stream_pc0", 129'(pc_o), 129'(32'h100));
        offer(32'h104); cycle(); check("stream_pc1", 129'(pc_o), 129'(32'h104));
        offer(32'h108); cycle(); check("stream_pc2", 129'(pc_o), 129'(32'h108));
        check("stream_valid", 129'(ins_valid_o), 129'(1'b1));
        check("stream_ready", 129'(fetch_ready_o), 129'(1'b1));
        idle_inputs(); cycle();

        // Fill under a full stall, then drain in order.
        stall_i = 6'b000110;
        offer(32'h100); cycle();
        offer(32'h104); cycle();
        offer(32'h108);
        check("fill_ready_low", 129'(fetch_ready_o), 129'(1'b0));
        cycle();
        check("fill_held_valid", 129'(ins_valid_o), 129'(1'b0));
        stall_i = 6'b0;
        cycle(); check("drain_pc0", 129'(pc_o), 129'(32'h100));
        check("drain_ready_back", 129'(fetch_ready_o), 129'(1'b1));
        cycle(); check("drain_pc1", 129'(pc_o), 129'(32'h104));
        fetch_valid_i = 1'b0;
        cycle(); check("drain_pc2", 129'(pc_o), 129'(32'h108));
        cycle(); check("drain_empty", 129'(ins_valid_o), 129'(1'b0));

        // Bubble: if_id stalled while id_ex runs inserts a NOP, keeps the entry.
        stall_i = 6'b000110; offer(32'h300); cycle();
        fetch_valid_i = 1'b0; stall_i = 6'b000010; cycle();
        check("bubble_ins", 129'(ins_o), 129'(32'h0000_0013));
        check("bubble_valid", 129'(ins_valid_o), 129'(1'b0));
        stall_i = 6'b0; cycle();
        check("bubble_resume_pc", 129'(pc_o), 129'(32'h300));
        cycle();

        // Flush drops queued entries and the beat offered on the same cycle.
        stall_i = 6'b000110;
        offer(32'h100); cycle();
        offer(32'h104); cycle();
        stall_i = 6'b0; flush_i = 1'b1; offer(32'h108); cycle();
        check("flush_ins", 129'(ins_o), 129'(32'h0000_0013));
        check("flush_valid", 129'(ins_valid_o), 129'(1'b0));
        check("flush_ready", 129'(fetch_ready_o), 129'(1'b1));
        flush_i = 1'b0; offer(32'h200); cycle();
        check("flush_next_pc", 129'(pc_o), 129'(32'h200));
        fetch_valid_i = 1'b0; cycle();
        check("flush_lost_beat", 129'(ins_valid_o), 129'(1'b0));

        // Flush beats a simultaneous full stall.
        stall_i = 6'b000110; offer(32'h400); cycle();
        flush_i = 1'b1; fetch_valid_i = 1'b0; cycle();
        check("flush_stall_ins", 129'(ins_o), 129'(32'h0000_0013));
        flush_i = 1'b0; stall_i = 6'b0; cycle();
        check("flush_stall_empty", 129'(ins_valid_o), 129'(1'b0));

        // Randomized soak against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_i   = ($urandom_range(0, 199) == 0);
            flush_i = ($urandom_range(0, 19) == 0);
            stall_i = 6'($urandom);
            if ($urandom_range(0, 9) < 6) stall_i[1] = 1'b0;
            if ($urandom_range(0, 9) < 7) offer(32'($urandom) & 32'hffff_fffc);
            else fetch_valid_i = 1'b0;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
